// File: rtl/tx_iq_streamer.sv
// Paces tx IQ samples from a first-word-fall-through FIFO to the DAC, one per strobe.
// Handles prefill, underrun zero-fill, a programmable zero tail and stream boundary pulses.
module tx_iq_streamer #(
  parameter int unsigned IQ_WIDTH    = 32,
  parameter int unsigned LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_strobe,
  input  logic                   phy_tx_started,
  input  logic                   phy_tx_done,
  input  logic                   fifo_empty,
  input  logic [IQ_WIDTH-1:0]    fifo_rd_data,
  input  logic [LEVEL_WIDTH-1:0] fifo_data_count,
  output logic                   fifo_rd_en,
  input  logic [LEVEL_WIDTH-1:0] start_level,
  input  logic [7:0]             tail_zero_count_top,
  output logic [IQ_WIDTH-1:0]    dac_iq,
  output logic                   dac_iq_valid,
  output logic                   tx_streaming,
  output logic                   pulse_stream_start,
  output logic                   pulse_stream_end,
  output logic                   underrun_pulse,
  output logic [15:0]            underrun_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_STREAM = 2'd2,
    S_TAIL   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                done_seen_q, done_seen_d;
  logic [7:0]          tail_cnt_q, tail_cnt_d;
  logic [IQ_WIDTH-1:0] dac_iq_q, dac_iq_d;
  logic                dac_iq_valid_q, dac_iq_valid_d;
  logic                tx_streaming_q, tx_streaming_d;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;
  logic                done_eff;

  // A done pulse on the current cycle counts as already seen.
  assign done_eff = done_seen_q | phy_tx_done;

  always_comb begin
    state_d        = state_q;
    done_seen_d    = done_seen_q | phy_tx_done;
    tail_cnt_d     = tail_cnt_q;
    dac_iq_d       = dac_iq_q;
    dac_iq_valid_d = sample_strobe;
    start_d        = 1'b0;
    end_d          = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    fifo_rd_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        dac_iq_d    = '0;
        tail_cnt_d  = 8'd0;
        done_seen_d = phy_tx_started & phy_tx_done;
        if (phy_tx_started) state_d = S_ARMED;
      end
      S_ARMED: begin
        dac_iq_d = '0;
        if ((fifo_data_count >= start_level) || (done_eff && !fifo_empty)) begin
          state_d = S_STREAM;
          start_d = 1'b1;
        end else if (done_eff && fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (sample_strobe) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            dac_iq_d   = fifo_rd_data;
          end else if (done_eff) begin
            dac_iq_d = '0;
            if (tail_zero_count_top == 8'd0) begin
              state_d = S_IDLE;
              end_d   = 1'b1;
            end else begin
              state_d    = S_TAIL;
              tail_cnt_d = 8'd0;
            end
          end else begin
            dac_iq_d   = '0;
            underrun_d = 1'b1;
            if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
          end
        end
      end
      S_TAIL: begin
        if (sample_strobe) begin
          dac_iq_d   = '0;
          tail_cnt_d = tail_cnt_q + 8'd1;
          if (tail_cnt_q == 8'(tail_zero_count_top - 8'd1)) begin
            state_d = S_IDLE;
            end_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) done_seen_d = 1'b0;
    tx_streaming_d = (state_d == S_STREAM) || (state_d == S_TAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      done_seen_q    <= 1'b0;
      tail_cnt_q     <= 8'd0;
      dac_iq_q       <= '0;
      dac_iq_valid_q <= 1'b0;
      tx_streaming_q <= 1'b0;
      start_q        <= 1'b0;
      end_q          <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      done_seen_q    <= done_seen_d;
      tail_cnt_q     <= tail_cnt_d;
      dac_iq_q       <= dac_iq_d;
      dac_iq_valid_q <= dac_iq_valid_d;
      tx_streaming_q <= tx_streaming_d;
      start_q        <= start_d;
      end_q          <= end_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign dac_iq             = dac_iq_q;
  assign dac_iq_valid       = dac_iq_valid_q;
  assign tx_streaming       = tx_streaming_q;
  assign pulse_stream_start = start_q;
  assign pulse_stream_end   = end_q;
  assign underrun_pulse     = underrun_q;
  assign underrun_count     = underrun_cnt_q;

endmodule

// File: tb/tb_tx_iq_streamer.sv
// Bench for tx_iq_streamer: FIFO model, strobe generator, output monitor,
// table-driven packet scenarios plus directed corner-case sequences.
module tb_tx_iq_streamer;
  localparam int unsigned IQW = 32;
  localparam int unsigned LW  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           sample_strobe;
  logic           phy_tx_started = 1'b0;
  logic           phy_tx_done = 1'b0;
  logic           fifo_empty;
  logic [IQW-1:0] fifo_rd_data;
  logic [LW-1:0]  fifo_data_count;
  logic           fifo_rd_en;
  logic [LW-1:0]  start_level = '0;
  logic [7:0]     tail_zero_count_top = 8'd0;
  logic [IQW-1:0] dac_iq;
  logic           dac_iq_valid, tx_streaming, pulse_stream_start, pulse_stream_end;
  logic           underrun_pulse;
  logic [15:0]    underrun_count;

  tx_iq_streamer #(.IQ_WIDTH(IQW), .LEVEL_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .phy_tx_started(phy_tx_started), .phy_tx_done(phy_tx_done),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en),
    .start_level(start_level), .tail_zero_count_top(tail_zero_count_top),
    .dac_iq(dac_iq), .dac_iq_valid(dac_iq_valid), .tx_streaming(tx_streaming),
    .pulse_stream_start(pulse_stream_start), .pulse_stream_end(pulse_stream_end),
    .underrun_pulse(underrun_pulse), .underrun_count(underrun_count)
  );

  // FWFT FIFO model
  logic [31:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_rd_data    = mem[rd_ptr[7:0]];
  assign fifo_data_count = LW'(wr_ptr - rd_ptr);
  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  // Strobe source: periodic when gap > 0, otherwise manual
  int   gap = 0;
  int   sc = 0;
  logic gen_strobe = 1'b0;
  logic man_strobe = 1'b0;
  assign sample_strobe = gen_strobe | man_strobe;
  always @(posedge clk) begin
    #1;
    if (gap == 0) begin
      gen_strobe = 1'b0;
      sc = 0;
    end else if (sc >= gap - 1) begin
      gen_strobe = 1'b1;
      sc = 0;
    end else begin
      gen_strobe = 1'b0;
      sc = sc + 1;
    end
  end

  // Output monitor
  logic [31:0] out_mem [4096];
  int out_n = 0, end_idx = 0, n_start = 0, n_end = 0, n_und = 0, n_rd = 0;
  always @(negedge clk) begin
    if (dac_iq_valid && out_n < 4096) begin
      out_mem[out_n] = dac_iq;
      out_n = out_n + 1;
    end
    if (pulse_stream_end) begin
      end_idx = out_n;
      n_end = n_end + 1;
    end
    if (pulse_stream_start) n_start = n_start + 1;
    if (underrun_pulse) n_und = n_und + 1;
    if (fifo_rd_en) n_rd = n_rd + 1;
  end

  int total = 0;
  int bad = 0;
  int wcount = 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_started();
    phy_tx_started = 1'b1; tick(1); phy_tx_started = 1'b0;
  endtask

  task automatic pulse_done();
    phy_tx_done = 1'b1; tick(1); phy_tx_done = 1'b0;
  endtask

  task automatic write_samples(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = 32'h1000_0000 + 32'(wcount) * 32'h0001_0003;
      wcount++;
      wr_ptr++;
      tick(1);
    end
  endtask

  // Nonzero outputs since snap must equal FIFO contents from rd0 onward
  task automatic check_stream(input string nm, input int snap, input int rd0, input int nexp,
                              input int exp_tail, input int exp_mid);
    int nz, first, last, errs;
    nz = 0; first = -1; last = -1; errs = 0;
    for (int i = snap; i < out_n; i++) begin
      if (out_mem[i] != 32'd0) begin
        if (out_mem[i] != mem[(rd0 + nz) % 256]) errs++;
        nz++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk({nm, " sample count"}, nz, nexp);
    chk({nm, " order errors"}, errs, 0);
    if (nexp > 0 && last >= 0) begin
      chk({nm, " mid-stream zeros"}, last - first + 1 - nz, exp_mid);
      chk({nm, " trailing zeros"}, end_idx - (last + 1), exp_tail);
    end
  endtask

  typedef struct {
    int    n;
    int    sl;
    int    tt;
    int    g;
    int    exp_start;
    int    exp_end;
    int    exp_tail;
    string name;
  } vec_t;

  vec_t vt [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, u0, r0, o0, rp0, rp1, to;

    vt[0] = '{10, 4,  3, 4, 1, 1, 4, "normal"};
    vt[1] = '{5,  16, 2, 3, 1, 1, 3, "short"};
    vt[2] = '{0,  4,  3, 4, 0, 0, 0, "empty"};
    vt[3] = '{6,  6,  0, 1, 1, 1, 1, "zero tail b2b"};
    vt[4] = '{3,  2,  1, 2, 1, 1, 2, "tail one"};

    // Reset state
    tick(3);
    chk("reset dac_iq", dac_iq, 0);
    chk("reset dac_iq_valid", dac_iq_valid, 0);
    chk("reset tx_streaming", tx_streaming, 0);
    chk("reset start pulse", pulse_stream_start, 0);
    chk("reset end pulse", pulse_stream_end, 0);
    chk("reset underrun pulse", underrun_pulse, 0);
    chk("reset underrun_count", underrun_count, 0);
    chk("reset fifo_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    tick(3);
    chk("idle tx_streaming", tx_streaming, 0);

    // Table-driven packets
    for (int k = 0; k < 5; k++) begin
      gap = vt[k].g;
      start_level = LW'(vt[k].sl);
      tail_zero_count_top = 8'(vt[k].tt);
      tick(5);
      s0 = n_start; e0 = n_end; u0 = n_und; r0 = n_rd; o0 = out_n; rp0 = rd_ptr;
      pulse_started();
      write_samples(vt[k].n);
      pulse_done();
      tick((vt[k].n + vt[k].tt + 4) * vt[k].g + 20);
      chk({vt[k].name, " start pulses"}, n_start - s0, vt[k].exp_start);
      chk({vt[k].name, " end pulses"}, n_end - e0, vt[k].exp_end);
      chk({vt[k].name, " rd_en pulses"}, n_rd - r0, vt[k].n);
      chk({vt[k].name, " underruns"}, n_und - u0, 0);
      chk({vt[k].name, " streaming after"}, tx_streaming, 0);
      check_stream(vt[k].name, o0, rp0, vt[k].n, vt[k].exp_tail, 0);
    end
    chk("underrun_count after table", underrun_count, 0);

    // Underrun: 4 samples, stall 3 strobes, 4 more, done
    gap = 4; start_level = LW'(4); tail_zero_count_top = 8'd2;
    tick(5);
    s0 = n_start; e0 = n_end; u0 = n_und; r0 = n_rd; o0 = out_n; rp0 = rd_ptr;
    pulse_started();
    write_samples(4);
    to = 0;
    while ((n_und - u0) < 3 && to < 200) begin
      tick(1);
      to++;
    end
    chk("underrun wait timeout", to < 200, 1);
    write_samples(4);
    pulse_done();
    tick(80);
    chk("underrun pulses", n_und - u0, 3);
    chk("underrun_count", underrun_count, 3);
    chk("underrun start pulses", n_start - s0, 1);
    chk("underrun end pulses", n_end - e0, 1);
    chk("underrun rd_en pulses", n_rd - r0, 8);
    check_stream("underrun", o0, rp0, 8, 3, 3);

    // Done coinciding with an empty-FIFO strobe: tail, not underrun
    gap = 0; start_level = LW'(1); tail_zero_count_top = 8'd0;
    tick(5);
    s0 = n_start; e0 = n_end; u0 = n_und; r0 = n_rd; o0 = out_n; rp0 = rd_ptr;
    pulse_started();
    write_samples(1);
    tick(4);
    man_strobe = 1'b1;
    tick(1);
    phy_tx_done = 1'b1;
    tick(1);
    phy_tx_done = 1'b0;
    man_strobe = 1'b0;
    tick(6);
    chk("coincident underruns", n_und - u0, 0);
    chk("coincident start pulses", n_start - s0, 1);
    chk("coincident end pulses", n_end - e0, 1);
    chk("coincident rd_en pulses", n_rd - r0, 1);
    check_stream("coincident", o0, rp0, 1, 1, 0);

    // Mid-stream reset after 3 of 8 samples
    gap = 4; start_level = LW'(8); tail_zero_count_top = 8'd1;
    tick(5);
    rp0 = rd_ptr;
    pulse_started();
    write_samples(8);
    to = 0;
    while ((rd_ptr - rp0) < 3 && to < 200) begin
      tick(1);
      to++;
    end
    chk("reset wait timeout", to < 200, 1);
    rst = 1'b1;
    #1;
    chk("midrst dac_iq", dac_iq, 0);
    chk("midrst tx_streaming", tx_streaming, 0);
    chk("midrst underrun_count", underrun_count, 0);
    chk("midrst fifo_rd_en", fifo_rd_en, 0);
    tick(2);
    chk("midrst dac_iq_valid", dac_iq_valid, 0);
    rst = 1'b0;
    rp1 = rd_ptr;
    chk("midrst popped before reset", rp1 - rp0, 3);
    tick(30);
    chk("no pop after reset", rd_ptr - rp1, 0);

    s0 = n_start; e0 = n_end; r0 = n_rd; o0 = out_n;
    pulse_started();
    pulse_done();
    tick(60);
    chk("restart start pulses", n_start - s0, 1);
    chk("restart end pulses", n_end - e0, 1);
    chk("restart rd_en pulses", n_rd - r0, 5);
    chk("restart underrun_count", underrun_count, 0);
    check_stream("restart", o0, rp1, 5, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_iq_streamer.md
# tx_iq_streamer

Reads transmit IQ samples out of the tx IQ FIFO and paces them to the DAC, one sample per `sample_strobe`. It sits on the read side of the FIFO whose write side is filled by the tx baseband chain. It holds off streaming until a prefill level is reached, zero-fills and counts underruns, appends a programmable zero tail, and signals stream boundaries. Its empty/non-empty transitions are what the tx activity detection logic observes.

## Interface
Parameters:
- `IQ_WIDTH`, 32, packed sample width, {I[31:16], Q[15:0]}
- `LEVEL_WIDTH`, 10, width of FIFO data count and prefill threshold

Ports:
- `clk`  in  1  single clock for all logic
- `rst`  in  1  reset, asynchronous, active-high
- `sample_strobe`  in  1  one-cycle pulse per DAC sample period
- `phy_tx_started`  in  1  pulse: baseband begins writing a packet
- `phy_tx_done`  in  1  pulse: baseband will write no more samples for this packet
- `fifo_empty`  in  1  FIFO empty flag (first-word-fall-through FIFO)
- `fifo_rd_data`  in  IQ_WIDTH  FIFO head word, valid when !fifo_empty
- `fifo_data_count`  in  LEVEL_WIDTH  FIFO occupancy
- `fifo_rd_en`  out  1  FIFO pop, combinational
- `start_level`  in  LEVEL_WIDTH  prefill threshold
- `tail_zero_count_top`  in  8  number of zero samples appended after the last sample
- `dac_iq`  out  IQ_WIDTH  sample to DAC, registered
- `dac_iq_valid`  out  1  registered copy of `sample_strobe`
- `tx_streaming`  out  1  high in STREAM or TAIL
- `pulse_stream_start`  out  1  one-cycle pulse when STREAM is entered
- `pulse_stream_end`  out  1  one-cycle pulse when TAIL/STREAM returns to IDLE
- `underrun_pulse`  out  1  one-cycle pulse per underrun sample
- `underrun_count`  out  16  underrun samples since reset, saturating at 0xFFFF

## Operation
- **States:** IDLE, ARMED, STREAM, TAIL.
- **`done_seen` flag:**
  - Set by `phy_tx_done` in any non-IDLE state, or when `phy_tx_done` coincides with `phy_tx_started` in IDLE.
  - Cleared on entry to IDLE.
- **IDLE → ARMED** on `phy_tx_started`. `phy_tx_started` is ignored in all other states.
- **ARMED:**
  - → STREAM when `fifo_data_count >= start_level` (unsigned compare), or when `done_seen && !fifo_empty`.
  - → IDLE when `done_seen && fifo_empty`. No start or end pulse is emitted on this path.
  - `start_level = 0` with a non-empty FIFO enters STREAM on the next cycle.
- **STREAM, on a cycle with `sample_strobe` high:**
  - `!fifo_empty`: `fifo_rd_en = 1`; `dac_iq <= fifo_rd_data`.
  - `fifo_empty && done_seen`: `dac_iq <= 0`; go to TAIL. If `tail_zero_count_top = 0`, go directly to IDLE and pulse `pulse_stream_end`.
  - `fifo_empty && !done_seen`: underrun. `dac_iq <= 0`, `underrun_pulse = 1`, `underrun_count` increments (saturating). Stay in STREAM.
- **TAIL:**
  - `tail_cnt` (8-bit) clears on TAIL entry and increments on each strobe, with `dac_iq <= 0`.
  - When the strobe that makes `tail_cnt == tail_zero_count_top - 1` occurs, go to IDLE and pulse `pulse_stream_end`.
  - The zero emitted at the STREAM→TAIL transition is not counted. Total trailing zeros = `tail_zero_count_top + 1` when `tail_zero_count_top > 0`, otherwise 1.
- **FIFO read enable:** `fifo_rd_en = sample_strobe && state == STREAM && !fifo_empty`. It is never asserted in any other state.
- **DAC outputs:**
  - `dac_iq_valid` follows every strobe in all states.
  - `dac_iq` is 0 in IDLE and ARMED.
- **Strobe spacing:** back-to-back strobes (one per cycle) are legal and are handled per cycle.
- **Reset:** `rst` asserted mid-packet forces IDLE immediately (asynchronous). The FIFO is not popped after that point.

## Timing
- **Reset values:** all outputs 0, state IDLE, `done_seen` 0, `tail_cnt` 0, `underrun_count` 0.
- **Sample latency:** strobe at cycle N → `dac_iq`/`dac_iq_valid` at N+1.
- **Start pulse:** `pulse_stream_start` in the first cycle in STREAM, i.e. one cycle after the threshold condition is sampled in ARMED.
- **End pulse:** `pulse_stream_end` in the cycle after the final strobe, aligned with the last zero on `dac_iq_valid`.
- **`tx_streaming`:** registered from state; high from the `pulse_stream_start` cycle through the last TAIL cycle.
- **Underrun alignment:** `underrun_pulse` is registered and aligned with the zero sample on `dac_iq_valid`.
- **Simultaneous events:**
  - `phy_tx_done` arriving on the same cycle as a STREAM strobe with `fifo_empty` counts as `done_seen` for that strobe: go to TAIL, no underrun.
  - `phy_tx_done` while in TAIL is harmless.

## Test plan
- **Normal packet:** `start_level` = 4; `phy_tx_started`; write 10 samples; `phy_tx_done`; strobe every 4 cycles; `tail_zero_count_top` = 3 → `pulse_stream_start` once; 10 samples on `dac_iq` in order; then exactly 4 zeros; `pulse_stream_end` once; 10 `fifo_rd_en` pulses; `underrun_count` = 0.
- **Underrun:** 4 samples prefilled; FIFO stalls for 3 strobes; then 4 more samples; done → 3 zero samples mid-stream; `underrun_count` = 3; 3 `underrun_pulse`s; stream continues with samples 5–8.
- **Short packet below threshold:** `start_level` = 16; 5 samples written, then done → ARMED exits on `done_seen`; all 5 samples streamed; tail as programmed.
- **Empty packet:** started then done, no writes → return to IDLE; no start or end pulse; `fifo_rd_en` never asserted.
- **Zero tail with back-to-back strobes:** `tail_zero_count_top` = 0, strobe every cycle → one trailing zero; `pulse_stream_end` one cycle after the empty strobe.
- **Mid-stream reset:** `rst` pulse after 3 of 8 samples → outputs 0 immediately; FIFO not popped afterward; `underrun_count` = 0; a new `phy_tx_started` operates normally.
